// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the fetch front end: datapath width, default PC
// values, instruction-memory latency and the fetch slot record carried down
// the delay line that tracks in-flight memory reads.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int XLEN         = 32;
  localparam int IMEM_LATENCY = 2;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP_DEFAULT  = 32'd4;

  // One in-flight fetch: the PC that was issued to memory and whether the
  // word that comes back for it is a real instruction.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            valid;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_delay_line.sv
// -----------------------------------------------------------------------------
// fetch_delay_line
// Shift register of fetch slots, one entry per cycle of instruction-memory
// latency, so the slot leaving the last entry lines up with the word that
// memory returns in the same cycle.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset; zeroes every entry
//   hold     in   keep every entry unchanged (wins over clear)
//   clear    in   drop the valid bit of every entry (squash wrong path)
//   in_slot  in   slot issued to memory this cycle
//   out_slot out  slot whose memory word arrives this cycle
// -----------------------------------------------------------------------------
module fetch_delay_line
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        clear,
  input  fetch_slot_t in_slot,
  output fetch_slot_t out_slot
);

  fetch_slot_t r_slot [IMEM_LATENCY];

  for (genvar gi = 0; gi < IMEM_LATENCY; gi++) begin : g_entry
    fetch_slot_t w_src;

    if (gi == 0) begin : g_head
      assign w_src = in_slot;
    end else begin : g_body
      assign w_src = r_slot[gi-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_slot[gi] <= '0;
      end else if (hold) begin
        r_slot[gi] <= r_slot[gi];
      end else if (clear) begin
        // PC bits are left as they are; only validity matters for a bubble.
        r_slot[gi].valid <= 1'b0;
      end else begin
        r_slot[gi] <= w_src;
      end
    end
  end

  assign out_slot = r_slot[IMEM_LATENCY-1];

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Front-end stage feeding decode. Owns the PC, presents it to instruction
// memory every cycle and carries each issued PC through a delay line that
// matches the memory read latency, so pc_out/bubble_out accompany the word
// decode is consuming. Applies halt > flush > stall > advance.
//
// Optional build macro: FETCH_PERF_EN adds the fetch_count and stall_count
// performance counter ports and their logic.
//
// Ports:
//   clk           in   clock
//   rst           in   synchronous active-high reset
//   stall         in   decode stall; freeze PC and delay line
//   flush         in   redirect from back end
//   flush_target  in   new PC when flush=1 (no alignment check)
//   halt          in   freeze all state
//   mem_addr      out  instruction-memory read address (current PC)
//   pc_out        out  PC of the word arriving at decode this cycle
//   bubble_out    out  arriving word is invalid
//   fetch_count   out  valid instructions delivered   (FETCH_PERF_EN)
//   stall_count   out  stalled, non-halted cycles      (FETCH_PERF_EN)
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_target,
  input  logic            halt,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] pc_out,
  output logic            bubble_out
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] fetch_count,
  output logic [XLEN-1:0] stall_count
`endif
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            w_hold;
  fetch_slot_t     w_issue_slot;
  fetch_slot_t     w_arrive_slot;

  // Halt freezes everything regardless of flush; a plain stall only holds
  // when no flush is pending, since the redirect must take effect.
  assign w_hold = halt | (stall & ~flush);

  always_comb begin
    w_pc_next = r_pc + PC_STEP;  // modulo 2^XLEN wrap is intended
    if (halt) begin
      w_pc_next = r_pc;
    end else if (flush) begin
      w_pc_next = flush_target;
    end else if (stall) begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign w_issue_slot = '{pc: r_pc, valid: 1'b1};

  fetch_delay_line u_delay_line (
    .clk      (clk),
    .rst      (rst),
    .hold     (w_hold),
    .clear    (flush),
    .in_slot  (w_issue_slot),
    .out_slot (w_arrive_slot)
  );

  assign mem_addr   = r_pc;
  assign pc_out     = w_arrive_slot.pc;
  assign bubble_out = ~w_arrive_slot.valid;

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] r_fetch_count;
  logic [XLEN-1:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else if (!halt) begin
      // A word counts as delivered only when decode actually accepts it.
      if (w_arrive_slot.valid && !stall && !flush) begin
        r_fetch_count <= r_fetch_count + 1'b1;
      end
      if (stall) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. Each task queues the outputs it expects
// after every clock edge it drives, then pops and compares once the edge has
// happened. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    logic        bub;
    logic        chk_pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, halt;
  logic [31:0] flush_target;
  logic [31:0] mem_addr, pc_out;
  logic        bubble_out;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count;
`endif

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .flush_target (flush_target),
    .halt         (halt),
    .mem_addr     (mem_addr),
    .pc_out       (pc_out),
    .bubble_out   (bubble_out)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count  (fetch_count),
    .stall_count  (stall_count)
`endif
  );

  task automatic push(input logic [31:0] a, input logic [31:0] p,
                      input logic b, input logic c);
    exp_t e;
    e.addr = a; e.pc = p; e.bub = b; e.chk_pc = c;
    sb.push_back(e);
  endtask

  task automatic set_in(input logic s, input logic f, input logic h,
                        input logic [31:0] t);
    stall = s; flush = f; halt = h; flush_target = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    push(32'h0, 32'h0, 1'b1, 1'b1);
    begin
      exp_t e = sb.pop_front();
      n_checks++;
      if (mem_addr !== e.addr || pc_out !== e.pc || bubble_out !== e.bub) begin
        n_fail++;
        $display("FAIL reset: got addr=%h pc=%h bub=%b, expected addr=%h pc=%h bub=%b",
                 mem_addr, pc_out, bubble_out, e.addr, e.pc, e.bub);
      end
`ifdef FETCH_PERF_EN
      n_checks++;
      if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_counters: got fetch=%0d stall=%0d, expected 0/0",
                 fetch_count, stall_count);
      end
`endif
    end
    rst = 1'b0;
  endtask

  // From reset: 4 free edges, pc reaches 0x10.
  task automatic test_free_run();
    for (int k = 1; k <= 4; k++) begin
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      push(32'(4*k), (k < 2) ? 32'h0 : 32'(4*(k-2)), (k < 2), 1'b1);
      @(posedge clk); #1;
      begin
        exp_t e = sb.pop_front();
        n_checks++;
        if (mem_addr !== e.addr || bubble_out !== e.bub || (e.chk_pc && pc_out !== e.pc)) begin
          n_fail++;
          $display("FAIL free_run[%0d]: got addr=%h pc=%h bub=%b, expected addr=%h pc=%h bub=%b",
                   k, mem_addr, pc_out, bubble_out, e.addr, e.pc, e.bub);
        end
      end
    end
  endtask

  // pc=0x10: stall 3 edges, release 4 edges -> pc reaches 0x20.
  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 1'b0, 1'b0, 32'h0);
      push(32'h10, 32'h08, 1'b0, 1'b1);
    end
    push(32'h14, 32'h0C, 1'b0, 1'b1);
    push(32'h18, 32'h10, 1'b0, 1'b1);
    push(32'h1C, 32'h14, 1'b0, 1'b1);
    push(32'h20, 32'h18, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      set_in(k < 3, 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      begin
        exp_t e = sb.pop_front();
        n_checks++;
        if (mem_addr !== e.addr || bubble_out !== e.bub || (e.chk_pc && pc_out !== e.pc)) begin
          n_fail++;
          $display("FAIL stall[%0d]: got addr=%h pc=%h bub=%b, expected addr=%h pc=%h bub=%b",
                   k, mem_addr, pc_out, bubble_out, e.addr, e.pc, e.bub);
        end
      end
    end
  endtask

  // Generic redirect: one edge with the given controls, then free running.
  task automatic test_flush(input string name, input logic [31:0] tgt,
                            input logic with_stall, input int n_free);
    logic [31:0] a;
    a = tgt;
    push(a, 32'h0, 1'b1, 1'b0);
    a = a + 32'd4;
    push(a, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < n_free - 1; k++) begin
      a = a + 32'd4;
      push(a, tgt + 32'(4*k), 1'b0, 1'b1);
    end
    for (int k = 0; k <= n_free; k++) begin
      if (k == 0) set_in(with_stall, 1'b1, 1'b0, tgt);
      else        set_in(1'b0, 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      begin
        exp_t e = sb.pop_front();
        n_checks++;
        if (mem_addr !== e.addr || bubble_out !== e.bub || (e.chk_pc && pc_out !== e.pc)) begin
          n_fail++;
          $display("FAIL %s[%0d]: got addr=%h pc=%h bub=%b, expected addr=%h pc=%h bub=%b",
                   name, k, mem_addr, pc_out, bubble_out, e.addr, e.pc, e.bub);
        end
      end
    end
  endtask

  // Entered with pc=0x48, pc_out=0x40 valid. Halt with flush+stall asserted
  // changes nothing; afterwards the stream resumes.
  task automatic test_halt();
    push(32'h48, 32'h40, 1'b0, 1'b1);
    push(32'h48, 32'h40, 1'b0, 1'b1);
    push(32'h4C, 32'h44, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      if (k < 2) set_in(1'b1, 1'b1, 1'b1, 32'h999);
      else       set_in(1'b0, 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      begin
        exp_t e = sb.pop_front();
        n_checks++;
        if (mem_addr !== e.addr || bubble_out !== e.bub || (e.chk_pc && pc_out !== e.pc)) begin
          n_fail++;
          $display("FAIL halt[%0d]: got addr=%h pc=%h bub=%b, expected addr=%h pc=%h bub=%b",
                   k, mem_addr, pc_out, bubble_out, e.addr, e.pc, e.bub);
        end
      end
    end
  endtask

  // Reset asserted together with stall and flush discards everything.
  task automatic test_reset_mid();
    rst = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 32'h500);
    push(32'h0, 32'h0, 1'b1, 1'b1);
    @(posedge clk); #1;
    begin
      exp_t e = sb.pop_front();
      n_checks++;
      if (mem_addr !== e.addr || pc_out !== e.pc || bubble_out !== e.bub) begin
        n_fail++;
        $display("FAIL reset_mid: got addr=%h pc=%h bub=%b, expected addr=%h pc=%h bub=%b",
                 mem_addr, pc_out, bubble_out, e.addr, e.pc, e.bub);
      end
    end
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

`ifdef FETCH_PERF_EN
  // 10 free edges deliver 8 words (first two are bubbles); 3 stalls count 3.
  task automatic test_perf();
    test_reset();
    repeat (10) @(posedge clk);
    stall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stall = 1'b0;
    n_checks++;
    if (fetch_count !== 32'd8 || stall_count !== 32'd3) begin
      n_fail++;
      $display("FAIL perf_counts: got fetch=%0d stall=%0d, expected 8/3",
               fetch_count, stall_count);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (fetch_count !== 32'd0 || stall_count !== 32'd0 || bubble_out !== 1'b1) begin
      n_fail++;
      $display("FAIL perf_reset: got fetch=%0d stall=%0d bub=%b, expected 0/0/1",
               fetch_count, stall_count, bubble_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_flush("flush", 32'h100, 1'b0, 3);
    test_flush("flush_stall", 32'h40, 1'b1, 2);
    test_halt();
    test_flush("wrap", 32'hFFFF_FFF8, 1'b0, 4);
    test_reset_mid();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
